// File: rtl/ifu_fetch_if.sv
// Fetch-unit signal bundle: controller inputs, instruction-memory handshake and IR/PC outputs.
// master = fetch unit, slave = the controller/memory side that drives it.
interface ifu_fetch_if;
  logic [1:0]  npc_sel;
  logic        pc_wr;
  logic [31:0] reg_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        align_err;
  logic [31:0] retired;

  modport master (
    input  npc_sel, pc_wr, reg_target, imem_rdata, imem_ready,
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, align_err, retired
  );

  modport slave (
    output npc_sel, pc_wr, reg_target, imem_rdata, imem_ready,
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, align_err, retired
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register, IR, ready-handshake fetch and next-PC commit.
// Two-state FSM: FETCH waits for imem_ready, HOLD presents the IR until the controller commits.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_3000,
  parameter logic [1:0]  NPC_PC_ADD_4 = 2'b00,
  parameter logic [1:0]  NPC_BEQ_JMP  = 2'b01,
  parameter logic [1:0]  NPC_J_JMP    = 2'b10,
  parameter logic [1:0]  NPC_REG_JMP  = 2'b11
) (
  input logic        clk,
  input logic        rst,
  ifu_fetch_if.master bus
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] retired_q;
  logic        align_err_q;
  logic [31:0] pc_plus4;
  logic [31:0] npc;
  logic        load_ir;
  logic        commit;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    npc = pc_plus4;
    unique case (bus.npc_sel)
      NPC_PC_ADD_4: npc = pc_plus4;
      NPC_BEQ_JMP:  npc = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
      NPC_J_JMP:    npc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
      NPC_REG_JMP:  npc = {bus.reg_target[31:2], 2'b00};
      default:      npc = pc_plus4;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    load_ir   = 1'b0;
    commit    = 1'b0;
    unique case (state)
      FETCH: begin
        if (bus.imem_ready) begin
          load_ir   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.pc_wr) begin
          commit    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      retired_q   <= '0;
      align_err_q <= 1'b0;
    end else begin
      if (load_ir) ir_q <= bus.imem_rdata;
      if (commit) begin
        pc_q      <= npc;
        retired_q <= retired_q + 32'd1;
        // A misaligned jr target is truncated to a word address and flagged until reset.
        if (bus.npc_sel == NPC_REG_JMP && bus.reg_target[1:0] != 2'b00)
          align_err_q <= 1'b1;
      end
    end
  end

  assign bus.imem_req    = (state == FETCH) && !rst;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = ir_q;
  assign bus.instr_valid = (state == HOLD);
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.align_err   = align_err_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: stimulus pushes the expected IR/PC state of each fetch into a
// scoreboard queue, and a monitor pops and compares whenever instr_valid rises.
module tb_ifu_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] retired;
    logic        align;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  ifu_fetch_if bus ();

  ifu_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares the presented instruction against the scoreboard on every instr_valid rise.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.instr_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("mon_pc",      bus.pc,              e.pc);
        check("mon_instr",   bus.instr,           e.instr);
        check("mon_retired", bus.retired,         e.retired);
        check("mon_align",   {31'd0, bus.align_err}, {31'd0, e.align});
      end
    end
    prev_valid = bus.instr_valid;
  end

  // Called at posedge+1 in FETCH; memory answers after 'waits' not-ready cycles.
  task automatic fetch(input int waits, input logic [31:0] word, input logic [31:0] exp_pc,
                       input logic [31:0] exp_ret, input logic exp_align, input logic wr_in_fetch);
    bus.imem_ready = 1'b0;
    bus.pc_wr      = wr_in_fetch;
    bus.npc_sel    = 2'b00;
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      check("fetch_req",      {31'd0, bus.imem_req},    32'd1);
      check("fetch_addr",     bus.imem_addr,            exp_pc);
      check("fetch_pcplus4",  bus.pc_plus4,             exp_pc + 32'd4);
      check("fetch_notvalid", {31'd0, bus.instr_valid}, 32'd0);
      check("fetch_retired",  bus.retired,              exp_ret);
      if (i == waits) begin
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        sb_q.push_back('{pc: exp_pc, instr: word, retired: exp_ret, align: exp_align});
      end
      @(posedge clk); #1;
    end
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    bus.pc_wr      = 1'b0;
  endtask

  // Called at posedge+1 in HOLD; commits one instruction and checks the new PC.
  task automatic commit(input logic [1:0] sel, input logic [31:0] regt,
                        input logic [31:0] exp_pc, input logic [31:0] exp_ret, input logic exp_align);
    bus.npc_sel    = sel;
    bus.reg_target = regt;
    bus.pc_wr      = 1'b1;
    @(posedge clk); #1;
    bus.pc_wr = 1'b0;
    @(negedge clk);
    check("commit_pc",      bus.pc,                 exp_pc);
    check("commit_retired", bus.retired,            exp_ret);
    check("commit_align",   {31'd0, bus.align_err}, {31'd0, exp_align});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    bus.npc_sel    = 2'b00;
    bus.pc_wr      = 1'b0;
    bus.reg_target = 32'h0;
    bus.imem_rdata = 32'h0;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    check("rst_req_low", {31'd0, bus.imem_req}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.imem_ready = 1'b0;
    @(negedge clk);
    check("rst_pc",      bus.pc,                   32'h0000_3000);
    check("rst_instr",   bus.instr,                32'h0);
    check("rst_valid",   {31'd0, bus.instr_valid}, 32'd0);
    check("rst_align",   {31'd0, bus.align_err},   32'd0);
    check("rst_retired", bus.retired,              32'd0);
    @(posedge clk); #1;

    // Zero-wait fetch (this fetch takes a second FETCH cycle after reset release already checked above).
    fetch(0, 32'h0000_0020, 32'h0000_3000, 32'd0, 1'b0, 1'b0);
    commit(2'b00, 32'h0, 32'h0000_3004, 32'd1, 1'b0);

    // Three wait states with pc_wr asserted throughout FETCH: must be ignored.
    fetch(3, 32'h0000_0021, 32'h0000_3004, 32'd1, 1'b0, 1'b1);
    commit(2'b00, 32'h0, 32'h0000_3008, 32'd2, 1'b0);

    // beq backward: 300C + (-2 << 2) = 3004; beq forward: 3008 + (3 << 2) = 3014.
    fetch(1, 32'h1000_FFFE, 32'h0000_3008, 32'd2, 1'b0, 1'b0);
    commit(2'b01, 32'h0, 32'h0000_3004, 32'd3, 1'b0);
    fetch(0, 32'h1000_0003, 32'h0000_3004, 32'd3, 1'b0, 1'b0);
    commit(2'b01, 32'h0, 32'h0000_3014, 32'd4, 1'b0);

    // j with IR[25:0]=0C10 -> 0000_3040.
    fetch(0, 32'h0800_0C10, 32'h0000_3014, 32'd4, 1'b0, 1'b0);
    commit(2'b10, 32'h0, 32'h0000_3040, 32'd5, 1'b0);

    // jr to misaligned 3011 -> 3010 with sticky align_err.
    fetch(0, 32'h03E0_0008, 32'h0000_3040, 32'd5, 1'b0, 1'b0);
    commit(2'b11, 32'h0000_3011, 32'h0000_3010, 32'd6, 1'b1);
    fetch(0, 32'h0000_0022, 32'h0000_3010, 32'd6, 1'b1, 1'b0);

    // pc_wr held across two edges: only the HOLD edge commits.
    bus.npc_sel = 2'b00;
    bus.pc_wr   = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.pc_wr = 1'b0;
    @(negedge clk);
    check("hold2_pc",      bus.pc,                 32'h0000_3014);
    check("hold2_retired", bus.retired,            32'd7);
    check("hold2_align",   {31'd0, bus.align_err}, 32'd1);
    @(posedge clk); #1;
    fetch(0, 32'h03E0_0008, 32'h0000_3014, 32'd7, 1'b1, 1'b0);

    // Wrap-around: FFFF_FFFC + 4 -> 0, then backward branch below zero -> FFFF_FFFC.
    commit(2'b11, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd8, 1'b1);
    fetch(0, 32'h0000_0023, 32'hFFFF_FFFC, 32'd8, 1'b1, 1'b0);
    commit(2'b00, 32'h0, 32'h0000_0000, 32'd9, 1'b1);
    fetch(0, 32'h1000_FFFE, 32'h0000_0000, 32'd9, 1'b1, 1'b0);
    commit(2'b01, 32'h0, 32'hFFFF_FFFC, 32'd10, 1'b1);
    fetch(0, 32'h0000_0024, 32'hFFFF_FFFC, 32'd10, 1'b1, 1'b0);

    // Reset in HOLD with a concurrent pc_wr: reset wins, then fetch restarts.
    rst         = 1'b1;
    bus.pc_wr   = 1'b1;
    bus.npc_sel = 2'b00;
    @(posedge clk); #1;
    rst       = 1'b0;
    bus.pc_wr = 1'b0;
    @(negedge clk);
    check("midrst_pc",      bus.pc,                   32'h0000_3000);
    check("midrst_retired", bus.retired,              32'd0);
    check("midrst_valid",   {31'd0, bus.instr_valid}, 32'd0);
    check("midrst_align",   {31'd0, bus.align_err},   32'd0);
    check("midrst_instr",   bus.instr,                32'h0);
    @(posedge clk); #1;
    fetch(0, 32'h0000_0025, 32'h0000_3000, 32'd0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
